// File: rtl/service_protocol_encoder_pkg.sv
// ServiceProtocol shared definitions.
// Holds the command codes, header field offsets, the trailer word and the
// checksum/word-building helpers. The encoder and the decoder both use it,
// so the framing cannot drift apart between the two ends of the link.
package ServiceProtocol;

    // Command codes carried in the low byte of the size/cmd word
    localparam logic [7:0] TCC_SEND_DATA    = 8'hA2;
    localparam logic [7:0] TCC_REQUEST_DATA = 8'hB0;

    // Field offsets within the two header words
    localparam int HDR_ADDR_LSB = 8;   // word 0: {addr, 8'h00}
    localparam int SZ_SIZE_LSB  = 8;   // word 1: {size, cmd_code}
    localparam int SZ_CMD_LSB   = 0;

    localparam logic [15:0] TRAILER_WORD = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_SZ, S_DWAIT, S_DPUSH, S_CSUM, S_TRAIL, S_DONE
    } enc_state_t;

    // Checksum is a plain 16-bit sum; the carry out is dropped
    function automatic logic [15:0] csum_add(input logic [15:0] acc,
                                             input logic [15:0] word);
        return acc + word;
    endfunction

    function automatic logic [15:0] hdr_word(input logic [7:0] addr);
        logic [15:0] w;
        w = '0;
        w[HDR_ADDR_LSB +: 8] = addr;
        return w;
    endfunction

    function automatic logic [15:0] sz_word(input logic [7:0] size,
                                            input logic [7:0] cmd_code);
        logic [15:0] w;
        w = '0;
        w[SZ_SIZE_LSB +: 8] = size;
        w[SZ_CMD_LSB  +: 8] = cmd_code;
        return w;
    endfunction

endpackage

// File: rtl/service_protocol_encoder.sv
// Service protocol packet encoder.
// Builds one packet per accepted start: {addr,00}, {size,cmd}, payload words
// pulled from an in_request/in_done source, a 16-bit additive checksum and an
// optional trailer word. Words are pushed out with an out_request/out_done
// handshake.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, addr,
//   cmd_code, size      packet request, sampled only when idle
//   busy                packet in progress
//   in_request, in_data payload source offers a word
//   in_done             payload word taken (one-cycle pulse)
//   out_request,
//   out_data, out_done  outgoing word handshake
//   packet_done         one-cycle pulse after the final word is accepted
module service_protocol_encoder
    import ServiceProtocol::*;
#(
    parameter bit TRAILER_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  addr,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  size,
    output logic        busy,
    input  logic        in_request,
    input  logic [15:0] in_data,
    output logic        in_done,
    output logic        out_request,
    output logic [15:0] out_data,
    input  logic        out_done,
    output logic        packet_done
);

    enc_state_t  state, state_nxt;
    logic [7:0]  size_q;
    logic [7:0]  cmd_q;
    logic [7:0]  cnt;
    logic [15:0] csum;

    logic        take_start;
    logic        accept;
    logic        load_word;
    logic        sum_word;
    logic [15:0] next_word;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_HDR;
            S_HDR:   if (accept)     state_nxt = S_SZ;
            S_SZ:    if (accept)     state_nxt = (size_q != 8'd0) ? S_DWAIT : S_CSUM;
            S_DWAIT: if (in_request) state_nxt = S_DPUSH;
            S_DPUSH: if (accept)     state_nxt = (cnt == 8'd1) ? S_CSUM : S_DWAIT;
            S_CSUM:  if (accept)     state_nxt = TRAILER_EN ? S_TRAIL : S_DONE;
            S_TRAIL: if (accept)     state_nxt = S_DONE;
            S_DONE:                  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy        = (state != S_IDLE) && (state != S_DONE);
        packet_done = (state == S_DONE);
        in_done     = (state == S_DWAIT) && in_request;
        take_start  = (state == S_IDLE) && start;
        // out_done only counts while a word is actually offered
        accept      = out_request && out_done;
        sum_word    = (state == S_HDR) || (state == S_SZ) || (state == S_DPUSH);
        // After an accept the request stays low for one cycle, then these
        // states present their word. HDR is loaded at start, payload words
        // are loaded straight from in_data.
        load_word   = !out_request &&
                      ((state == S_SZ) || (state == S_CSUM) || (state == S_TRAIL));
        case (state)
            S_SZ:    next_word = sz_word(size_q, cmd_q);
            S_CSUM:  next_word = csum;
            S_TRAIL: next_word = TRAILER_WORD;
            default: next_word = '0;
        endcase
    end

    // Datapath: outgoing word register, checksum accumulator, payload counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_request <= 1'b0;
            out_data    <= '0;
            csum        <= '0;
            cnt         <= '0;
            size_q      <= '0;
            cmd_q       <= '0;
        end else if (take_start) begin
            size_q      <= size;
            cmd_q       <= cmd_code;
            cnt         <= size;
            csum        <= '0;
            out_data    <= hdr_word(addr);
            out_request <= 1'b1;
        end else if (accept) begin
            out_request <= 1'b0;
            if (sum_word)
                csum <= csum_add(csum, out_data);
            if (state == S_DPUSH)
                cnt <= cnt - 8'd1;
        end else if (in_done) begin
            out_data    <= in_data;
            out_request <= 1'b1;
        end else if (load_word) begin
            out_data    <= next_word;
            out_request <= 1'b1;
        end
    end

endmodule
